// File: rtl/scan_chain_sequencer_if.sv
// Pin-mux side bundle of the scan-chain sequencer: refresh request/response
// plus the serial chain control lines.
interface scan_chain_sequencer_if;
  logic       start;
  logic [8:0] active_select;
  logic [7:0] inputs;
  logic [7:0] outputs;
  logic       busy;
  logic       ready;
  logic       scan_clk;
  logic       scan_data_out;
  logic       scan_data_in;
  logic       scan_select;
  logic       scan_latch_en;

  // Pin mux / chain environment side
  modport master (
    output start, active_select, inputs, scan_data_in,
    input  outputs, busy, ready, scan_clk, scan_data_out, scan_select, scan_latch_en
  );

  // Sequencer side
  modport slave (
    input  start, active_select, inputs, scan_data_in,
    output outputs, busy, ready, scan_clk, scan_data_out, scan_select, scan_latch_en
  );
endinterface

// File: rtl/scan_chain_sequencer.sv
// Scan-chain sequencer: one refresh = capture all design outputs, shift the
// whole chain (injecting/extracting the selected slot), then latch the chain
// into the design inputs. All chain-facing outputs are registered.
module scan_chain_sequencer #(
  parameter int NUM_DESIGNS = 250,
  parameter int HALF_PERIOD = 1
) (
  input logic                   clk,
  input logic                   reset,
  scan_chain_sequencer_if.slave bus
);
  localparam int L  = NUM_DESIGNS * 8;
  localparam int BW = $clog2(L);
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(L - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, LATCH, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] phase_q;    // cycle within the current scan_clk half-period
  logic          hi_q;       // 0: first (low) half, 1: second half
  logic [BW-1:0] bit_q;      // shift step k
  logic [BW-1:0] base_q;     // first step of the selected slot's window
  logic          valid_q;    // selected slot exists in the chain
  logic [7:0]    din_q;
  logic [7:0]    shadow_q;
  logic [7:0]    outputs_q;
  logic          busy_q, ready_q, sclk_q, sdo_q, ssel_q, slat_q;

  logic          phase_last_d;
  logic          sel_ok_d;
  logic [BW-1:0] base_d;
  logic [BW-1:0] bit_inc_d;
  logic [BW-1:0] nxt_step_d;
  logic [BW:0]   cur_off_d, nxt_off_d;
  logic          cur_win_d, nxt_win_d;
  logic          nxt_data_d;

  assign phase_last_d = (phase_q == PH_LAST);
  assign sel_ok_d     = (32'(bus.active_select) < NUM_DESIGNS);
  assign base_d       = BW'((NUM_DESIGNS - 1 - int'(bus.active_select)) * 8);
  assign bit_inc_d    = bit_q + 1'b1;

  // Window tests use one extra bit so steps before the window wrap to a
  // large offset instead of aliasing into 0..7.
  assign cur_off_d  = {1'b0, bit_q} - {1'b0, base_q};
  assign cur_win_d  = valid_q && (cur_off_d < (BW+1)'(8));

  // Data for the step about to start: step 0 when leaving CAPTURE, k+1 in SHIFT.
  assign nxt_step_d = (state_q == SHIFT) ? bit_inc_d : '0;
  assign nxt_off_d  = {1'b0, nxt_step_d} - {1'b0, base_q};
  assign nxt_win_d  = valid_q && (nxt_off_d < (BW+1)'(8));
  assign nxt_data_d = nxt_win_d & din_q[~nxt_off_d[2:0]];

  assign bus.outputs       = outputs_q;
  assign bus.busy          = busy_q;
  assign bus.ready         = ready_q;
  assign bus.scan_clk      = sclk_q;
  assign bus.scan_data_out = sdo_q;
  assign bus.scan_select   = ssel_q;
  assign bus.scan_latch_en = slat_q;

  // Refresh FSM with half-period divider, step counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      hi_q      <= 1'b0;
      bit_q     <= '0;
      base_q    <= '0;
      valid_q   <= 1'b0;
      din_q     <= '0;
      shadow_q  <= '0;
      outputs_q <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      ssel_q    <= 1'b0;
      slat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            valid_q <= sel_ok_d;
            din_q   <= sel_ok_d ? bus.inputs : 8'h00;
            base_q  <= base_d;
            phase_q <= '0;
            hi_q    <= 1'b0;
            busy_q  <= 1'b1;
            ssel_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!phase_last_d) begin
            phase_q <= phase_q + 1'b1;
          end else begin
            phase_q <= '0;
            if (!hi_q) begin
              hi_q   <= 1'b1;
              sclk_q <= 1'b1;
            end else begin
              hi_q    <= 1'b0;
              sclk_q  <= 1'b0;
              ssel_q  <= 1'b0;
              bit_q   <= '0;
              sdo_q   <= nxt_data_d;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (!phase_last_d) begin
            phase_q <= phase_q + 1'b1;
          end else begin
            phase_q <= '0;
            if (!hi_q) begin
              // End of the low phase: the tail bit is stable, take it now.
              hi_q   <= 1'b1;
              sclk_q <= 1'b1;
              if (cur_win_d) shadow_q[~cur_off_d[2:0]] <= bus.scan_data_in;
            end else begin
              hi_q   <= 1'b0;
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                sdo_q   <= 1'b0;
                slat_q  <= 1'b1;
                state_q <= LATCH;
              end else begin
                bit_q <= bit_inc_d;
                sdo_q <= nxt_data_d;
              end
            end
          end
        end
        LATCH: begin
          if (!phase_last_d) begin
            phase_q <= phase_q + 1'b1;
          end else begin
            phase_q <= '0;
            if (!hi_q) begin
              hi_q <= 1'b1;
            end else begin
              hi_q    <= 1'b0;
              slat_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (valid_q) outputs_q <= shadow_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
